// File: rtl/dma_sched_pkg.sv
// Shared definitions for the 2A03 bus-sharing DMA scheduler.
// The package holds the state encoding, the default OAM port and the get/put phase constants.
package dma_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_HALT      = 3'd1,
      ST_ALIGN     = 3'd2,
      ST_SPR_RD    = 3'd3,
      ST_SPR_WR    = 3'd4,
      ST_DPCM_RD   = 3'd5,
      ST_DPCM_SKIP = 3'd6
   } state_e;

   localparam logic [15:0] OAM_PORT_DEF = 16'h2004;
   localparam int          SPR_LEN_DEF  = 256;

   localparam logic PH_GET = 1'b0;
   localparam logic PH_PUT = 1'b1;

endpackage

// File: rtl/dma_sched_if.sv
// Request/bus bundle between the register decoder, the CPU bus mux and the DMA scheduler.
// sprdma_we and dpcm_req are single-cycle strobes with no back-pressure, and dpcm_ack is a single-cycle valid for dpcm_data with no ready.
interface dma_sched_if;

   logic        sprdma_we;
   logic [7:0]  sprdma_page;
   logic        dpcm_req;
   logic [15:0] dpcm_addr;
   logic        cpu_rw;
   logic [7:0]  din;

   logic        rdy;
   logic        dma_active;
   logic [15:0] addr;
   logic        rw;
   logic [7:0]  dout;
   logic        phase;
   logic        dpcm_ack;
   logic [7:0]  dpcm_data;

   modport slave (
      input  sprdma_we, sprdma_page, dpcm_req, dpcm_addr, cpu_rw, din,
      output rdy, dma_active, addr, rw, dout, phase, dpcm_ack, dpcm_data
   );

   modport master (
      output sprdma_we, sprdma_page, dpcm_req, dpcm_addr, cpu_rw, din,
      input  rdy, dma_active, addr, rw, dout, phase, dpcm_ack, dpcm_data
   );

endinterface

// File: rtl/dma_sched_phase_gen.sv
// Get/put cycle parity generator; reset value is get and it toggles on every clock.
// align_needed_o is high on get cycles, because leaving HALT then would land the first transfer on a put cycle.
module dma_phase_gen
   import dma_sched_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   output logic phase_o,
   output logic align_needed_o
);

   logic phase_q;
   logic phase_d;

   assign phase_d = ~phase_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q <= PH_GET;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign phase_o        = phase_q;
   assign align_needed_o = (phase_q == PH_GET);

endmodule

// File: rtl/dma_sched.sv
// Arbitrates the CPU bus between the CPU, sprite (OAM) DMA and DPCM sample fetches.
// The CPU is halted through rdy, and DPCM fetches take priority at every get slot.
module dma_sched
   import dma_sched_pkg::*;
#(
   parameter logic [15:0] OAM_PORT = OAM_PORT_DEF,
   parameter int          SPR_LEN  = SPR_LEN_DEF
) (
   input  logic        CLK,
   input  logic        n_RES,
   dma_sched_if.slave  bus,
   output state_e      dbg_state_o
);

   localparam logic [7:0] LAST_CNT = 8'(SPR_LEN - 1);

   state_e      state_q, state_d;
   logic        spr_pend_q, spr_pend_d;
   logic        dpcm_pend_q, dpcm_pend_d;
   logic [7:0]  page_q, page_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  latch_q, latch_d;
   logic [15:0] dpcm_addr_q, dpcm_addr_d;
   logic [7:0]  dpcm_data_q, dpcm_data_d;
   logic        dpcm_ack_q, dpcm_ack_d;

   logic        phase;
   logic        align_needed;
   logic        spr_take;
   logic        dpcm_take;
   logic        spr_last;
   logic        spr_more;
   logic        dpcm_want;
   state_e      next_xfer;

   logic        rdy_c;
   logic        dma_active_c;
   logic [15:0] addr_c;
   logic        rw_c;
   logic [7:0]  dout_c;

   dma_phase_gen u_phase (
      .clk_i          (CLK),
      .rst_ni         (n_RES),
      .phase_o        (phase),
      .align_needed_o (align_needed)
   );

   // A DPCM request arriving in a deciding cycle is already eligible for the next get slot.
   assign spr_take  = bus.sprdma_we && (state_q == ST_IDLE) && !spr_pend_q;
   assign dpcm_take = bus.dpcm_req && !dpcm_pend_q;
   assign spr_last  = (state_q == ST_SPR_WR) && (cnt_q == LAST_CNT);
   assign spr_more  = spr_pend_q && !spr_last;
   assign dpcm_want = dpcm_pend_q || dpcm_take;

   always_comb begin
      next_xfer = ST_IDLE;
      if (dpcm_want) begin
         next_xfer = ST_DPCM_RD;
      end else if (spr_more) begin
         next_xfer = ST_SPR_RD;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (spr_pend_q || dpcm_pend_q) begin
               state_d = ST_HALT;
            end
         end
         ST_HALT: begin
            // Only a CPU read cycle can be stolen; writes must complete first.
            if (bus.cpu_rw) begin
               state_d = align_needed ? ST_ALIGN : next_xfer;
            end
         end
         ST_ALIGN:     state_d = next_xfer;
         ST_SPR_RD:    state_d = ST_SPR_WR;
         ST_SPR_WR:    state_d = next_xfer;
         ST_DPCM_RD:   state_d = ST_DPCM_SKIP;
         ST_DPCM_SKIP: state_d = next_xfer;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      spr_pend_d  = spr_pend_q;
      dpcm_pend_d = dpcm_pend_q;
      page_d      = page_q;
      cnt_d       = cnt_q;
      latch_d     = latch_q;
      dpcm_addr_d = dpcm_addr_q;
      dpcm_data_d = dpcm_data_q;
      dpcm_ack_d  = (state_q == ST_DPCM_RD);

      if (spr_take) begin
         spr_pend_d = 1'b1;
         page_d     = bus.sprdma_page;
         cnt_d      = 8'd0;
      end
      if (spr_last) begin
         spr_pend_d = 1'b0;
      end
      if (dpcm_take) begin
         dpcm_pend_d = 1'b1;
         dpcm_addr_d = bus.dpcm_addr;
      end

      unique case (state_q)
         ST_SPR_RD:  latch_d = bus.din;
         ST_SPR_WR:  cnt_d   = cnt_q + 8'd1;
         ST_DPCM_RD: begin
            dpcm_data_d = bus.din;
            dpcm_pend_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         state_q     <= ST_IDLE;
         spr_pend_q  <= 1'b0;
         dpcm_pend_q <= 1'b0;
         page_q      <= 8'd0;
         cnt_q       <= 8'd0;
         latch_q     <= 8'd0;
         dpcm_addr_q <= 16'd0;
         dpcm_data_q <= 8'd0;
         dpcm_ack_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         spr_pend_q  <= spr_pend_d;
         dpcm_pend_q <= dpcm_pend_d;
         page_q      <= page_d;
         cnt_q       <= cnt_d;
         latch_q     <= latch_d;
         dpcm_addr_q <= dpcm_addr_d;
         dpcm_data_q <= dpcm_data_d;
         dpcm_ack_q  <= dpcm_ack_d;
      end
   end

   // Bus outputs are decoded from the state alone, so reset clears them at once.
   always_comb begin
      rdy_c        = (state_q == ST_IDLE);
      dma_active_c = (state_q != ST_IDLE) && (state_q != ST_HALT);
      addr_c       = 16'd0;
      rw_c         = 1'b1;
      dout_c       = 8'd0;
      unique case (state_q)
         ST_SPR_RD: addr_c = {page_q, cnt_q};
         ST_SPR_WR: begin
            addr_c = OAM_PORT;
            rw_c   = 1'b0;
            dout_c = latch_q;
         end
         ST_DPCM_RD, ST_DPCM_SKIP: addr_c = dpcm_addr_q;
         default: ;
      endcase
   end

   assign bus.rdy        = rdy_c;
   assign bus.dma_active = dma_active_c;
   assign bus.addr       = addr_c;
   assign bus.rw         = rw_c;
   assign bus.dout       = dout_c;
   assign bus.phase      = phase;
   assign bus.dpcm_ack   = dpcm_ack_q;
   assign bus.dpcm_data  = dpcm_data_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_dma_sched.sv
// Randomised scoreboard bench for dma_sched: a byte-per-address memory model drives din,
// expected bus cycles, sample bytes and rdy-low run lengths are queued at stimulus time.
module tb_dma_sched;
  import dma_sched_pkg::*;

  logic   CLK = 1'b0;
  logic   n_RES;
  state_e dbg_state;
  logic [7:0] salt = 8'h00;

  dma_sched_if bus ();

  dma_sched u_dut (
    .CLK         (CLK),
    .n_RES       (n_RES),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] mem_byte(input logic [15:0] a, input logic [7:0] s);
    return a[7:0] ^ {a[2:0], a[15:11]} ^ s;
  endfunction

  assign bus.din = mem_byte(bus.addr, salt);

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc;
  logic [24:0] exp_spr_q[$];
  logic [15:0] exp_dbus_q[$];
  logic [7:0]  exp_dpcm_q[$];
  int          exp_len_q[$];
  int          exp_align = 0;
  int          run = 0;
  logic [24:0] mon_e;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_event(input string name, input string got, input string want);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %s, expected %s", name, got, want);
  endfunction

  // reference cycle counter: cycle 0 is the one before the first edge after reset release
  always @(posedge CLK or negedge n_RES) begin
    if (!n_RES) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (!n_RES) begin
      run = 0;
    end else begin
      check("phase", 32'(bus.phase), 32'(cyc[0]));
      check("no_dma_while_cpu_writes", 32'(bus.dma_active && !bus.cpu_rw), 32'd0);
      if (bus.dma_active) begin
        if (bus.addr == 16'h0000) begin
          check("align_expected", 32'(exp_align > 0), 32'd1);
          check("align_phase", 32'(cyc[0]), 32'(PH_PUT));
          if (exp_align > 0) exp_align--;
        end else if (!bus.addr[15]) begin
          if (exp_spr_q.size() == 0) begin
            fail_event("spr_extra", $sformatf("cycle addr %h rw %0d", bus.addr, bus.rw), "no sprite cycle");
          end else begin
            mon_e = exp_spr_q.pop_front();
            check("spr_addr", 32'(bus.addr), 32'(mon_e[24:9]));
            check("spr_rw", 32'(bus.rw), 32'(mon_e[8]));
            if (!mon_e[8]) check("spr_dout", 32'(bus.dout), 32'(mon_e[7:0]));
            check("spr_phase", 32'(cyc[0]), mon_e[8] ? 32'(PH_GET) : 32'(PH_PUT));
          end
        end else begin
          if (exp_dbus_q.size() == 0) begin
            fail_event("dpcm_bus_extra", $sformatf("cycle addr %h", bus.addr), "no dpcm cycle");
          end else begin
            check("dpcm_bus_addr", 32'(bus.addr), 32'(exp_dbus_q.pop_front()));
            check("dpcm_bus_rw", 32'(bus.rw), 32'd1);
          end
        end
      end else begin
        check("idle_bus", 32'({bus.addr, bus.rw, bus.dout}), 32'({16'h0000, 1'b1, 8'h00}));
      end
      if (bus.dpcm_ack) begin
        if (exp_dpcm_q.size() == 0) fail_event("dpcm_ack_extra", "ack pulse", "no ack");
        else check("dpcm_data", 32'(bus.dpcm_data), 32'(exp_dpcm_q.pop_front()));
      end
      if (!bus.rdy) begin
        run++;
      end else if (run > 0) begin
        if (exp_len_q.size() == 0) fail_event("rdy_low_extra", $sformatf("%0d low cycles", run), "no halt");
        else check("rdy_low_len", 32'(run), 32'(exp_len_q.pop_front()));
        run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_dpcm(input logic [15:0] da);
    bus.dpcm_req  = 1'b1;
    bus.dpcm_addr = da;
    exp_dpcm_q.push_back(mem_byte(da, salt));
    exp_dbus_q.push_back(da);
    exp_dbus_q.push_back(da);
  endtask

  task automatic push_sprite(input logic [7:0] page);
    for (int i = 0; i < 256; i++) begin
      exp_spr_q.push_back({page, 8'(i), 1'b1, 8'h00});
      exp_spr_q.push_back({16'h2004, 1'b0, mem_byte({page, 8'(i)}, salt)});
    end
  endtask

  // dpcm_mode: 0 none, 1 with the strobe, 2 in the first halt cycle, 3 during the read of byte $3F
  task automatic run_dma(input bit do_spr, input logic [7:0] page, input int stall_n,
                         input logic want_par, input int dpcm_mode, input logic [15:0] da);
    int  c;
    int  extra;
    bit  seen;
    @(negedge CLK);
    if (cyc[0] != want_par) @(negedge CLK);
    if (do_spr) begin
      bus.sprdma_we   = 1'b1;
      bus.sprdma_page = page;
      push_sprite(page);
    end
    if (dpcm_mode == 1) issue_dpcm(da);
    @(negedge CLK);
    bus.sprdma_we = 1'b0;
    bus.dpcm_req  = 1'b0;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      if (!bus.rdy) seen = 1;
      else @(negedge CLK);
    end
    if (!seen) begin
      fail_event("halt_timeout", "rdy stayed 1", "rdy 0");
      return;
    end
    c = int'(cyc);
    if (dpcm_mode == 2) issue_dpcm(da);
    bus.cpu_rw = (stall_n == 0);
    for (int k = 0; k < stall_n; k++) begin
      @(negedge CLK);
      bus.dpcm_req = 1'b0;
    end
    bus.cpu_rw = 1'b1;
    extra = (((c + stall_n) % 2) == 0) ? 1 : 0;
    exp_align += extra;
    exp_len_q.push_back(stall_n + 1 + extra + (do_spr ? 512 : 0) + (dpcm_mode != 0 ? 2 : 0));
    if (stall_n == 0) begin
      @(negedge CLK);
      bus.dpcm_req = 1'b0;
    end
    if (dpcm_mode == 3) begin
      seen = 0;
      for (int k = 0; k < 400 && !seen; k++) begin
        @(negedge CLK);
        if (bus.dma_active && bus.rw && bus.addr == {page, 8'h3F}) seen = 1;
      end
      if (!seen) fail_event("mid_read_timeout", "no read of byte 3F", "read of byte 3F");
      else begin
        issue_dpcm(da);
        @(negedge CLK);
        bus.dpcm_req = 1'b0;
      end
    end
    seen = 0;
    for (int k = 0; k < 800 && !seen; k++) begin
      @(negedge CLK);
      if (bus.rdy) seen = 1;
    end
    if (!seen) fail_event("done_timeout", "rdy stayed 0", "rdy 1");
    repeat (3) @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},        32'(bus.rdy),        32'd1);
    check({tag, "_dma_active"}, 32'(bus.dma_active), 32'd0);
    check({tag, "_addr"},       32'(bus.addr),       32'd0);
    check({tag, "_rw"},         32'(bus.rw),         32'd1);
    check({tag, "_dout"},       32'(bus.dout),       32'd0);
    check({tag, "_phase"},      32'(bus.phase),      32'd0);
    check({tag, "_dpcm_ack"},   32'(bus.dpcm_ack),   32'd0);
    check({tag, "_dpcm_data"},  32'(bus.dpcm_data),  32'd0);
    check({tag, "_state"},      32'(dbg_state),      32'(ST_IDLE));
  endtask

  task automatic reset_mid(input logic [7:0] page);
    bit seen;
    @(negedge CLK);
    bus.sprdma_we   = 1'b1;
    bus.sprdma_page = page;
    push_sprite(page);
    @(negedge CLK);
    bus.sprdma_we = 1'b0;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      if (!bus.rdy) seen = 1;
      else @(negedge CLK);
    end
    if (!seen) fail_event("rst_halt_timeout", "rdy stayed 1", "rdy 0");
    if ((cyc % 2) == 0) exp_align++;
    seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge CLK);
      if (bus.dma_active && bus.rw && bus.addr == {page, 8'h80}) seen = 1;
    end
    if (!seen) fail_event("rst_read_timeout", "no read of byte 80", "read of byte 80");
    @(negedge CLK);
    check("rst_in_write", 32'(bus.rw), 32'd0);
    #1 n_RES = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_spr_q.delete();
    exp_dbus_q.delete();
    exp_dpcm_q.delete();
    exp_len_q.delete();
    exp_align = 0;
    repeat (3) @(negedge CLK);
    #1 n_RES = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      check("post_rst_rdy", 32'(bus.rdy), 32'd1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         spr;
    int         mode;
    logic [7:0] pg;
    n_RES           = 1'b1;
    bus.sprdma_we   = 1'b0;
    bus.sprdma_page = 8'h00;
    bus.dpcm_req    = 1'b0;
    bus.dpcm_addr   = 16'h0000;
    bus.cpu_rw      = 1'b1;
    #1 n_RES = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (3) @(negedge CLK);
    #1 n_RES = 1'b1;

    salt = 8'($urandom_range(0, 255));
    run_dma(1, 8'h02, 0, PH_PUT, 0, 16'h0000);   // 513 low cycles
    run_dma(1, 8'h02, 0, PH_GET, 0, 16'h0000);   // 514 low cycles, one align
    run_dma(1, 8'h03, 2, PH_PUT, 0, 16'h0000);   // CPU writing for 2 halt cycles
    run_dma(0, 8'h00, 0, PH_PUT, 1, 16'hC000);   // idle DPCM fetch, 3 low cycles
    run_dma(0, 8'h00, 0, PH_GET, 1, 16'hC000);   // idle DPCM fetch, 4 low cycles
    run_dma(1, 8'h02, 0, PH_PUT, 3, 16'hC000);   // DPCM before sprite read of $0240
    run_dma(1, 8'h04, 1, PH_GET, 2, 16'hC123);   // DPCM arriving in HALT

    for (int it = 0; it < 6; it++) begin
      salt = 8'($urandom_range(0, 255));
      spr  = int'($urandom_range(0, 1));
      mode = (spr != 0) ? int'($urandom_range(0, 3)) : 1;
      pg   = 8'($urandom_range(1, 7));
      run_dma(spr[0], pg, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), mode,
              {2'b11, 14'($urandom_range(0, 16383))});
    end

    reset_mid(8'h05);
    salt = 8'($urandom_range(0, 255));
    run_dma(1, 8'h06, 0, PH_PUT, 2, 16'hE001);

    check("end_spr_q_empty",  32'(exp_spr_q.size()),  32'd0);
    check("end_dbus_q_empty", 32'(exp_dbus_q.size()), 32'd0);
    check("end_dpcm_q_empty", 32'(exp_dpcm_q.size()), 32'd0);
    check("end_len_q_empty",  32'(exp_len_q.size()),  32'd0);
    check("end_align_zero",   32'(exp_align),         32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got time limit reached, expected stimulus to finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dma_sched.md
Name: dma_sched

Overview:
- Bus-sharing scheduler for the 2A03 core: arbitrates the CPU address/data bus between the CPU, sprite (OAM) DMA and DPCM sample DMA.
- Halts the CPU via RDY, sequences 256 read/write pairs to $2004 for sprite DMA, and inserts single-byte DPCM fetches with priority.
- Sits between the register decoder ($4014 strobe, DPCM channel request) and the external bus mux.

Parameters:
- OAM_PORT, 16'h2004, write address for sprite DMA put cycles.
- SPR_LEN, 256, bytes per sprite DMA (the counter is 8 bits; values other than 256 are not supported).

Ports:
- CLK  in  1  CPU cycle clock (M2 rate); all state on rising edge.
- n_RES  in  1  asynchronous active-low reset.
- sprdma_we  in  1  one-cycle strobe: CPU wrote $4014.
- sprdma_page  in  8  page written to $4014, sampled with sprdma_we.
- dpcm_req  in  1  one-cycle request for one sample byte.
- dpcm_addr  in  16  DPCM fetch address, sampled with dpcm_req.
- cpu_rw  in  1  CPU bus direction in the current cycle; 1 = read.
- din  in  8  bus read data, valid at the end of a DMA read cycle.
- rdy  out  1  1 = CPU may proceed; 0 = CPU halted.
- dma_active  out  1  1 = DMA owns addr/rw/dout this cycle.
- addr  out  16  DMA bus address.
- rw  out  1  DMA bus direction; 1 = read.
- dout  out  8  DMA write data.
- phase  out  1  cycle parity; 0 = get, 1 = put.
- dpcm_ack  out  1  one-cycle pulse: dpcm_data is valid.
- dpcm_data  out  8  fetched sample byte.

Behaviour:
- Reset (n_RES=0, async) forces the following regardless of in-flight transfer:
  - rdy=1, dma_active=0, addr=0, rw=1, dout=0, phase=0, dpcm_ack=0, dpcm_data=0.
  - state=IDLE, counters 0, pending flags cleared.
- phase toggles every CLK from the first edge after reset release.
- States: IDLE, HALT, ALIGN, SPR_RD, SPR_WR, DPCM_RD, DPCM_SKIP.
- Latching requests:
  - sprdma_we in IDLE latches the page and sets spr_pend. It is ignored while sprite DMA is pending or active.
  - dpcm_req latches the address and sets dpcm_pend. It is ignored while dpcm_pend=1.
- IDLE -> HALT when either pend flag is set. rdy drops to 0 in the first HALT cycle.
- HALT cycle handling:
  - The cycle is consumed only if cpu_rw=1; otherwise stay in HALT (the CPU is finishing writes).
  - The CPU does not own the bus for the consumed halt cycle.
- Leaving HALT:
  - Go to the first transfer if the next cycle is get (phase=0).
  - Otherwise go to ALIGN for one cycle, then the first transfer.
- Transfer selection on a get cycle:
  - dpcm_pend=1 -> DPCM_RD.
  - Else spr active -> SPR_RD.
- SPR_RD (get):
  - Drive addr={page,cnt}, rw=1; capture din into the data latch.
  - Next state SPR_WR.
- SPR_WR (put):
  - Drive addr=OAM_PORT, rw=0, dout=latch; cnt++.
  - If cnt was 255: sprite DMA is done.
- DPCM_RD (get):
  - Drive addr=dpcm_addr, rw=1; capture din into dpcm_data.
  - Pulse dpcm_ack in the following cycle; clear dpcm_pend.
- DPCM_SKIP follows DPCM_RD:
  - Occurs on the next put cycle; dma_active=1, rw=1, addr=dpcm_addr (dummy).
  - Then resume the interrupted sprite read on the next get, or finish.
  - A DPCM fetch interleaved into sprite DMA costs exactly 2 cycles.
- Completion: with no pend flags and no sprite DMA active, go to IDLE. rdy=1 in the first IDLE cycle.
- Expected cycle counts:
  - Sprite-only DMA: 513 cycles (halt on put) or 514 cycles (halt on get) of rdy=0.
  - Idle DPCM-only fetch: 3 or 4 cycles of rdy=0.
- dma_active=1 in every non-IDLE, non-HALT state. In IDLE/HALT: addr/rw/dout hold their reset values.
- A dpcm_req arriving during HALT or ALIGN is served first at the first get slot.

Decomposition:
- Shared include/package holds:
  - state encoding localparams (7 states, 3-bit).
  - OAM_PORT default.
  - Phase constants GET=0, PUT=1.
- One sub-module, dma_phase_gen: parity toggle plus an align-needed flag. Everything else stays in dma_sched.

Test Plan:
- Reset, then sprdma_we with page=8'h02 while the CPU reads, HALT on a put cycle -> rdy=0 for 513 cycles.
  - Reads $0200..$02FF, each followed by a write to $2004 with the same byte.
  - rdy=1 on cycle 514.
- Same, but HALT lands on a get cycle -> one ALIGN cycle; 514 cycles of rdy=0; first read address $0200.
- sprdma_we while cpu_rw=0 for 2 cycles -> remains in HALT for 2 extra cycles; bus untouched (dma_active=0).
- dpcm_req addr=16'hC000 in IDLE -> rdy=0 for 3 or 4 cycles.
  - Read of $C000; dpcm_ack pulse with dpcm_data=din.
  - No $2004 writes.
- dpcm_req mid sprite DMA at cnt=8'h40 -> sprite read of $0240 deferred by exactly 2 cycles.
  - Total 515 or 516 cycles; dpcm_ack pulses once.
- n_RES low during SPR_WR at cnt=8'h80 -> outputs take reset values immediately.
  - After release, rdy=1 and no DMA activity until a new strobe.
